// File: rtl/mvau_wmem_pkg.sv
// Shared types and helpers for the PE-banked MVAU weight memory.
package mvau_wmem_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } wmem_state_t;

    localparam int unsigned DEF_PE           = 32'd2;
    localparam int unsigned DEF_SIMD         = 32'd2;
    localparam int unsigned DEF_TW           = 32'd1;
    localparam int unsigned DEF_WMEM_DEPTH   = 32'd4;
    localparam int unsigned DEF_WMEM_ADDR_BW = 32'd2;

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int unsigned cnt_bw(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/mvau_wmem_bank.sv
// One PE weight bank: simple dual-port RAM, one write port, registered read port.
module mvau_wmem_bank #(
    parameter int unsigned DW    = 32'd2,
    parameter int unsigned DEPTH = 32'd4,
    parameter int unsigned AW    = 32'd2
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    (* ram_style = "auto" *) logic [DW-1:0] mem_r [DEPTH];
    logic [DW-1:0] rdata_r;

    // Write port; array contents are deliberately left out of reset.
    always_ff @(posedge aclk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port; holds its word between reads.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rdata_r <= {DW{1'b0}};
        end else if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/mvau_weight_mem_pe.sv
// Runtime-loadable PE-banked MVAU weight memory: load FSM, banks, range check.
// Optional macro MVAU_WMEM_OREG_EN adds an output register (read latency 2).
module mvau_weight_mem_pe
    import mvau_wmem_pkg::*;
#(
    parameter int unsigned PE           = DEF_PE,
    parameter int unsigned SIMD         = DEF_SIMD,
    parameter int unsigned TW           = DEF_TW,
    parameter int unsigned WMEM_DEPTH   = DEF_WMEM_DEPTH,
    parameter int unsigned WMEM_ADDR_BW = DEF_WMEM_ADDR_BW
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     wload_start,
    input  logic                     wload_valid,
    output logic                     wload_ready,
    input  logic [SIMD*TW-1:0]       wload_data,
    output logic                     wload_done,
    input  logic                     rd_en,
    input  logic [WMEM_ADDR_BW-1:0]  rd_addr,
    output logic                     rd_ready,
    output logic [PE*SIMD*TW-1:0]    wmem_out,
    output logic                     wmem_valid
);

    localparam int unsigned DW    = SIMD * TW;
    localparam int unsigned OW    = PE * DW;
    localparam int unsigned PE_BW = cnt_bw(PE);
    localparam int unsigned AW    = cnt_bw(WMEM_DEPTH);

    wmem_state_t   state_r;
    wmem_state_t   state_nxt_s;
    logic          wload_ready_r;
    logic          wload_done_r;
    logic          rd_ready_r;
    logic [PE_BW-1:0] pe_cnt_r;
    logic [AW-1:0] addr_cnt_r;
    logic          accept_s;
    logic          last_beat_s;
    logic          rd_acc_s;
    logic          in_range_s;
    logic          in_range_r;
    logic          rd_vld_r;
    logic [OW-1:0] bank_q_s;
    logic [OW-1:0] rd_data_s;

    assign accept_s    = wload_valid & wload_ready_r;
    assign last_beat_s = accept_s && (pe_cnt_r == PE_BW'(PE - 1))
                                  && (addr_cnt_r == AW'(WMEM_DEPTH - 1));
    assign rd_acc_s    = rd_en & rd_ready_r;
    assign in_range_s  = ({1'b0, rd_addr} < (WMEM_ADDR_BW + 1)'(WMEM_DEPTH));

    // Next-state logic; a start always wins over completing the final beat.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            EMPTY: begin
                if (wload_start) state_nxt_s = LOAD;
                else             state_nxt_s = EMPTY;
            end
            LOAD: begin
                if (wload_start)      state_nxt_s = LOAD;
                else if (last_beat_s) state_nxt_s = READY;
                else                  state_nxt_s = LOAD;
            end
            READY: begin
                if (wload_start) state_nxt_s = LOAD;
                else             state_nxt_s = READY;
            end
            default: state_nxt_s = EMPTY;
        endcase
    end

    // State register; handshake flags are decoded from the next state so they track state_r.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r       <= EMPTY;
            wload_ready_r <= 1'b0;
            wload_done_r  <= 1'b0;
            rd_ready_r    <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            wload_ready_r <= (state_nxt_s == LOAD);
            wload_done_r  <= (state_nxt_s == READY);
            rd_ready_r    <= (state_nxt_s == READY);
        end
    end

    // Load counters: PE-minor, address-major; a start rewinds after any same-cycle write.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pe_cnt_r   <= {PE_BW{1'b0}};
            addr_cnt_r <= {AW{1'b0}};
        end else if (wload_start) begin
            pe_cnt_r   <= {PE_BW{1'b0}};
            addr_cnt_r <= {AW{1'b0}};
        end else if (accept_s) begin
            if (pe_cnt_r == PE_BW'(PE - 1)) begin
                pe_cnt_r <= {PE_BW{1'b0}};
                if (addr_cnt_r == AW'(WMEM_DEPTH - 1)) addr_cnt_r <= {AW{1'b0}};
                else                                   addr_cnt_r <= addr_cnt_r + AW'(1);
            end else begin
                pe_cnt_r <= pe_cnt_r + PE_BW'(1);
            end
        end
    end

    for (genvar p = 0; p < PE; p++) begin : g_bank
        mvau_wmem_bank #(
            .DW    (DW),
            .DEPTH (WMEM_DEPTH),
            .AW    (AW)
        ) u_bank (
            .aclk    (aclk),
            .aresetn (aresetn),
            .we      (accept_s && (pe_cnt_r == PE_BW'(p))),
            .waddr   (addr_cnt_r),
            .wdata   (wload_data),
            .re      (rd_acc_s),
            .raddr   (rd_addr[AW-1:0]),
            .rdata   (bank_q_s[p*DW +: DW])
        );
    end

    // Read-stage tracking; the range flag only changes on an accepted read so the output holds.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_vld_r   <= 1'b0;
            in_range_r <= 1'b0;
        end else begin
            rd_vld_r <= rd_acc_s;
            if (rd_acc_s) in_range_r <= in_range_s;
        end
    end

    assign rd_data_s = in_range_r ? bank_q_s : {OW{1'b0}};

`ifdef MVAU_WMEM_OREG_EN
    logic [OW-1:0] out_r;
    logic          out_vld_r;

    // Output register stage; captures only on a valid first-stage read.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_r     <= {OW{1'b0}};
            out_vld_r <= 1'b0;
        end else begin
            out_vld_r <= rd_vld_r;
            if (rd_vld_r) out_r <= rd_data_s;
        end
    end

    assign wmem_out   = out_r;
    assign wmem_valid = out_vld_r;
`else
    assign wmem_out   = rd_data_s;
    assign wmem_valid = rd_vld_r;
`endif

    assign wload_ready = wload_ready_r;
    assign wload_done  = wload_done_r;
    assign rd_ready    = rd_ready_r;

endmodule

// File: tb/tb_mvau_weight_mem_pe.sv
// Scoreboard bench for mvau_weight_mem_pe: directed scenarios plus randomized traffic.
module tb_mvau_weight_mem_pe;

    localparam int PE    = 2;
    localparam int SIMD  = 2;
    localparam int TW    = 4;
    localparam int DEPTH = 4;
    localparam int ABW   = 3;
    localparam int DW    = SIMD * TW;
    localparam int OW    = PE * DW;
`ifdef MVAU_WMEM_OREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          wload_start;
    logic          wload_valid;
    logic          wload_ready;
    logic [DW-1:0] wload_data;
    logic          wload_done;
    logic          rd_en;
    logic [ABW-1:0] rd_addr;
    logic          rd_ready;
    logic [OW-1:0] wmem_out;
    logic          wmem_valid;

    always #5 aclk = ~aclk;

    mvau_weight_mem_pe #(
        .PE(PE), .SIMD(SIMD), .TW(TW), .WMEM_DEPTH(DEPTH), .WMEM_ADDR_BW(ABW)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .wload_start(wload_start), .wload_valid(wload_valid), .wload_ready(wload_ready),
        .wload_data(wload_data), .wload_done(wload_done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .wmem_out(wmem_out), .wmem_valid(wmem_valid)
    );

    // Reference model: memory image, beat index k, and phase 0=empty 1=loading 2=loaded.
    typedef struct { logic [OW-1:0] data; int due; } exp_t;
    logic [DW-1:0] mdl_mem [PE][DEPTH];
    int            mdl_k;
    int            mdl_st;
    exp_t          sb_q[$];
    int            cyc;
    logic [OW-1:0] last_out;
    int            checks;
    int            errors;
    bit            dir_en;
    logic [OW-1:0] dir_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [OW-1:0] mdl_read(input int a);
        logic [OW-1:0] r;
        r = '0;
        if (a < DEPTH) begin
            for (int p = 0; p < PE; p++) r[p*DW +: DW] = mdl_mem[p][a];
        end
        return r;
    endfunction

    // One clock: apply the spec rules to whatever the inputs were at the edge.
    task automatic tick();
        bit   was_load;
        bit   was_ready;
        exp_t e;
        was_load  = (mdl_st == 1);
        was_ready = (mdl_st == 2);
        @(posedge aclk);
        cyc++;
        if (aresetn) begin
            if (was_ready && rd_en) begin
                e.data = dir_en ? dir_exp : mdl_read(int'(rd_addr));
                e.due  = cyc + LAT - 1;
                sb_q.push_back(e);
            end
            if (was_load && wload_valid) begin
                mdl_mem[mdl_k % PE][mdl_k / PE] = wload_data;
                mdl_k++;
            end
            if (wload_start) begin
                mdl_st = 1;
                mdl_k  = 0;
            end else if (was_load && mdl_k == PE * DEPTH) begin
                mdl_st = 2;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        wload_start = 1'b0; wload_valid = 1'b0; wload_data = 8'h00;
        rd_en = 1'b0; rd_addr = 3'd0; dir_en = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        aresetn = 1'b0;
        mdl_st = 0; mdl_k = 0; last_out = '0;
        sb_q.delete();
        tick(); tick();
        aresetn = 1'b1;
    endtask

    task automatic start_pulse();
        wload_start = 1'b1; tick(); wload_start = 1'b0;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input bit gap_after);
        wload_valid = 1'b1; wload_data = d; tick();
        wload_valid = 1'b0;
        if (gap_after) tick();
    endtask

    task automatic read_dir(input int a, input logic [OW-1:0] exp);
        rd_en = 1'b1; rd_addr = ABW'(a); dir_en = 1'b1; dir_exp = exp;
        tick();
        rd_en = 1'b0; dir_en = 1'b0;
    endtask

    // Monitor: control outputs against model phase, read data against the scoreboard.
    always @(negedge aclk) begin
        exp_t e;
        chk("wload_ready", {31'd0, wload_ready}, {31'd0, mdl_st == 1});
        chk("wload_done",  {31'd0, wload_done},  {31'd0, mdl_st == 2});
        chk("rd_ready",    {31'd0, rd_ready},    {31'd0, mdl_st == 2});
        if (wmem_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_valid", {31'd0, wmem_valid}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("rd_latency", cyc, e.due);
                chk("wmem_out", {16'd0, wmem_out}, {16'd0, e.data});
                last_out = e.data;
            end
        end else begin
            chk("wmem_hold", {16'd0, wmem_out}, {16'd0, last_out});
            if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                chk("missing_valid", {31'd0, wmem_valid}, 32'd1);
                void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        checks = 0; errors = 0; cyc = 0;
        mdl_st = 0; mdl_k = 0; last_out = '0;
        idle_inputs();
        aresetn = 1'b0;
        do_reset();

        // 1: reads before any load are ignored
        rd_en = 1'b1; rd_addr = 3'd0;
        repeat (5) tick();
        rd_en = 1'b0;

        // 2: gap-free load, read addr 2
        start_pulse();
        for (int i = 0; i < 8; i++) send_beat(8'((i + 1) * 8'h11), 1'b0);
        tick();
        read_dir(2, 16'h6655);
        repeat (3) tick();

        // 3: same load with valid toggling
        start_pulse();
        for (int i = 0; i < 8; i++) send_beat(8'((i + 1) * 8'h11), 1'b1);
        for (int a = 0; a < DEPTH; a++) read_dir(a, 16'(((2 * a + 2) * 8'h11) << 8) | 16'((2 * a + 1) * 8'h11));
        repeat (3) tick();

        // 4: restart after 3 beats, back-to-back reads
        start_pulse();
        for (int i = 0; i < 3; i++) send_beat(8'hB0 + 8'(i), 1'b0);
        start_pulse();
        for (int i = 0; i < 8; i++) send_beat(8'hA1 + 8'(i), 1'b0);
        read_dir(0, 16'hA2A1);
        read_dir(1, 16'hA4A3);
        read_dir(2, 16'hA6A5);
        read_dir(3, 16'hA8A7);

        // 5: out-of-range read
        read_dir(5, 16'h0000);
        repeat (3) tick();

        // 6: reset during load, then full reload
        start_pulse();
        for (int i = 0; i < 4; i++) send_beat(8'hC0 + 8'(i), 1'b0);
        do_reset();
        start_pulse();
        for (int i = 0; i < 8; i++) send_beat(8'h31 + 8'(i * 3), 1'b0);
        for (int a = 0; a < 8; a++) begin
            rd_en = 1'b1; rd_addr = ABW'(a); tick();
        end
        rd_en = 1'b0;

        // Start on the final beat restarts instead of entering READY
        start_pulse();
        for (int i = 0; i < 7; i++) send_beat(8'h50 + 8'(i), 1'b0);
        wload_start = 1'b1; send_beat(8'h57, 1'b0); wload_start = 1'b0;
        for (int i = 0; i < 8; i++) send_beat(8'h60 + 8'(i), 1'b0);

        // Read accepted together with a start still returns old data
        rd_en = 1'b1; rd_addr = 3'd1; wload_start = 1'b1; tick();
        rd_en = 1'b0; wload_start = 1'b0;
        repeat (3) tick();

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                wload_start = ($urandom_range(0, 39) == 0);
                wload_valid = 1'($urandom_range(0, 1));
                wload_data  = 8'($urandom);
                rd_en       = 1'($urandom_range(0, 1));
                rd_addr     = 3'($urandom_range(0, 7));
                tick();
            end
        end

        idle_inputs();
        repeat (LAT + 3) tick();
        chk("sb_drain", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
